// File: rtl/heap_port_b_master.sv
// heap_port_b_master: turns a valid/ready request stream into registered port B block-memory
// accesses and returns read data in order through a credit-protected response FIFO.
// Optional feature macro: HEAP_BOUNDS_CHECK_EN (flag out-of-range reads, drop out-of-range writes).
module heap_port_b_master #(
  parameter int CAPACITY_BYTES = 2048,
  parameter int WORD_BYTES     = 4,
  parameter int RSP_DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  input  logic [3:0]  req_byte_en,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_en,
  input  logic [31:0] mem_rd_data,
  output logic        busy
);
`ifdef HEAP_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [31:0]   ADDR_MASK = ~32'(WORD_BYTES - 1);
  localparam logic [31:0]   CAP       = 32'(CAPACITY_BYTES);
  localparam logic [PW-1:0] LAST      = PW'(RSP_DEPTH - 1);

  // Handshakes: a request transfers on a clk edge where req_valid && req_ready, a response
  // transfers where rsp_valid && rsp_ready; the producer holds its payload stable until then.
  logic          ready_en;
  logic          iss_rd, iss_err, wait_rd, wait_err;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fifo_data [RSP_DEPTH];
  logic          fifo_err  [RSP_DEPTH];
  logic          accept, oob, push, pop;
  logic [1:0]    inflight;
  logic [31:0]   used;

  // Every accepted read holds a FIFO slot from accept until pop, so a push never finds it full.
  assign inflight    = {1'b0, iss_rd} + {1'b0, wait_rd};
  assign used        = 32'(inflight) + 32'(fifo_count);
  assign req_ready   = ready_en && (used < 32'(RSP_DEPTH));
  assign accept      = req_valid && req_ready;
  assign oob         = BOUNDS_EN && (req_addr >= CAP);
  assign push        = wait_rd;
  assign pop         = rsp_valid && rsp_ready;
  assign rsp_valid   = (fifo_count != '0);
  assign rsp_rd_data = fifo_data[rd_ptr];
  assign rsp_error   = BOUNDS_EN && fifo_err[rd_ptr];
  assign busy        = (inflight != 2'd0) || rsp_valid;

  // Issue stage: iss_* marks the cycle the address is on port B, wait_* the cycle its data returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en    <= 1'b0;
      iss_rd      <= 1'b0;
      iss_err     <= 1'b0;
      wait_rd     <= 1'b0;
      wait_err    <= 1'b0;
      mem_address <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= '0;
    end else begin
      ready_en <= 1'b1;
      mem_wr_en <= '0;
      iss_rd   <= 1'b0;
      iss_err  <= 1'b0;
      wait_rd  <= iss_rd;
      wait_err <= iss_err;
      if (accept && !oob) begin
        mem_address <= req_addr & ADDR_MASK;
      end
      if (accept && req_write && !oob) begin
        mem_wr_data <= req_wr_data;
        mem_wr_en   <= req_byte_en;
      end
      if (accept && !req_write) begin
        iss_rd  <= 1'b1;
        iss_err <= oob;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= wait_err ? 32'h0 : mem_rd_data;
        fifo_err[wr_ptr]  <= wait_err;
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_heap_port_b_master.sv
// Bench for heap_port_b_master: block-memory model on port B, reference heap image, and
// scoreboard queues for read responses and port B write pulses.
module tb_heap_port_b_master;
  localparam int CAPACITY_BYTES = 2048;
  localparam int WORD_BYTES     = 4;
  localparam int RSP_DEPTH      = 2;
  localparam int MEM_WORDS      = CAPACITY_BYTES / WORD_BYTES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wr_data = '0;
  logic [3:0]  req_byte_en = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [31:0] rsp_rd_data, mem_address, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_en;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];     // {error, data}
  logic [67:0] exp_wr_q[$];  // {byte_en, word address, data}
  logic [31:0] bench_mem [MEM_WORDS];
  logic [31:0] ref_mem   [MEM_WORDS];
  bit          mem_loaded = 1'b0;
  bit          rand_bp = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_head = '0;

  heap_port_b_master #(
    .CAPACITY_BYTES(CAPACITY_BYTES), .WORD_BYTES(WORD_BYTES), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) bench_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mem_wr_en[k]) bench_mem[mem_address[10:2]][8*k +: 8] <= mem_wr_data[8*k +: 8];
    end
    mem_rd_data <= bench_mem[mem_address[10:2]];
  end

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a / WORD_BYTES) % MEM_WORDS);
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
`ifdef HEAP_BOUNDS_CHECK_EN
    return a >= 32'(CAPACITY_BYTES);
`else
    return (a != a);
`endif
  endfunction

  task automatic model_accept(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
    if (wr) begin
      if (!is_oob(a)) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
        if (be != 4'b0000) exp_wr_q.push_back({be, a & ~32'(WORD_BYTES - 1), d});
      end
    end else if (is_oob(a)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      exp_q.push_back({1'b0, ref_mem[widx(a)]});
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    int waited = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wr_data = d; req_byte_en = be;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=0 for %0d cycles, expected 1", waited);
      req_valid = 1'b0;
      return;
    end
    model_accept(wr, a, d, be);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_rsp_outstanding"}, 32'(exp_q.size()), 32'd0);
    check({name, "_wr_outstanding"}, 32'(exp_wr_q.size()), 32'd0);
    check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rd_data"}, rsp_rd_data, 32'd0);
    check({tag, "_rsp_error"}, {31'b0, rsp_error}, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_mem_wr_en"}, {28'b0, mem_wr_en}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    logic [67:0] w;
    if (reset_n) begin
      if (rsp_valid && prev_hold) check("rsp_head_stable", rsp_rd_data, prev_head);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got data 0x%08h, expected no response", rsp_rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rd_data", rsp_rd_data, e[31:0]);
          check("rsp_error", {31'b0, rsp_error}, {31'b0, e[32]});
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_head = rsp_rd_data;
      if (mem_wr_en != 4'b0000) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got mem_wr_en=0x%h, expected 0x0", mem_wr_en);
        end else begin
          w = exp_wr_q.pop_front();
          check("wr_byte_en", {28'b0, mem_wr_en}, {28'b0, w[67:64]});
          check("wr_address", mem_address, w[63:32]);
          check("wr_data", mem_wr_data, w[31:0]);
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("por");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_release", {31'b0, req_ready}, 32'd1);

    // Reset with two reads outstanding
    send(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    send(1'b0, 32'h104, 32'h0, 4'h0);
    send(1'b0, 32'h108, 32'h0, 4'h0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_read_reset");
    exp_q.delete();
    exp_wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_rerelease", {31'b0, req_ready}, 32'd1);
    repeat (3) @(posedge clk); #1;
    check("no_stale_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Write then read: one-cycle write pulse, read data two cycles after accept
    send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    check("wr_pulse_en", {28'b0, mem_wr_en}, 32'hF);
    send(1'b0, 32'h100, 32'h0, 4'h0);
    check("wr_pulse_one_cycle", {28'b0, mem_wr_en}, 32'h0);
    check("rd_lat_cycle1", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rd_lat_cycle2", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rd_lat_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_lat_data", rsp_rd_data, 32'hDEADBEEF);
    drain("write_read");

    // Byte mask and an all-lanes-off write
    send(1'b1, 32'h40, 32'h11223344, 4'hF);
    send(1'b1, 32'h42, 32'hAABBCCDD, 4'b0101);
    send(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000);
    check("zero_be_no_lanes", {28'b0, mem_wr_en}, 32'h0);
    send(1'b0, 32'h40, 32'h0, 4'h0);
    drain("byte_mask");

    // Backpressure: credit runs out after RSP_DEPTH reads
    rsp_ready = 1'b0;
    send(1'b0, 32'h200, 32'h0, 4'h0);
    send(1'b0, 32'h204, 32'h0, 4'h0);
    repeat (3) @(posedge clk); #1;
    check("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
    check("bp_busy", {31'b0, busy}, 32'd1);
    fork
      begin
        send(1'b0, 32'h208, 32'h0, 4'h0);
        send(1'b0, 32'h20C, 32'h0, 4'h0);
      end
      begin
        repeat (4) @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Streaming reads with the consumer always ready
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i * 4), 32'h0, 4'h0);
    check("stream_busy_after_last", {31'b0, busy}, 32'd1);
    repeat (3) @(posedge clk); #1;
    check("stream_busy_fall", {31'b0, busy}, 32'd0);
    drain("stream");

`ifdef HEAP_BOUNDS_CHECK_EN
    send(1'b0, 32'h800, 32'h0, 4'h0);
    send(1'b0, 32'h7FC, 32'h0, 4'h0);
    send(1'b1, 32'h800, 32'h12345678, 4'hF);
    check("oob_write_dropped", {28'b0, mem_wr_en}, 32'h0);
    drain("bounds");
`endif

    // Randomised traffic with random consumer backpressure
    rand_bp = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [31:0] a;
          a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(2048, 2303))
                                          : 32'($urandom_range(0, 2047));
          send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rand_bp = 1'b0;
      end
      begin
        while (rand_bp) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("random");
    check("final_req_ready", {31'b0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule
